// File: rtl/enigma_step_controller_pkg.sv
// Shared definitions for the Enigma rotor step controller: alphabet constants,
// controller state encoding and the mod-26 position increment.
package enigma_step_controller_pkg;

  localparam int NUM_LETTERS = 26;

  localparam logic [4:0] LTR_A = 5'd0,  LTR_B = 5'd1,  LTR_C = 5'd2,  LTR_D = 5'd3;
  localparam logic [4:0] LTR_E = 5'd4,  LTR_F = 5'd5,  LTR_G = 5'd6,  LTR_H = 5'd7;
  localparam logic [4:0] LTR_I = 5'd8,  LTR_J = 5'd9,  LTR_K = 5'd10, LTR_L = 5'd11;
  localparam logic [4:0] LTR_M = 5'd12, LTR_N = 5'd13, LTR_O = 5'd14, LTR_P = 5'd15;
  localparam logic [4:0] LTR_Q = 5'd16, LTR_R = 5'd17, LTR_S = 5'd18, LTR_T = 5'd19;
  localparam logic [4:0] LTR_U = 5'd20, LTR_V = 5'd21, LTR_W = 5'd22, LTR_X = 5'd23;
  localparam logic [4:0] LTR_Y = 5'd24, LTR_Z = 5'd25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_DRIVE,
    S_DONE,
    S_SEEK,
    S_GAP,
    S_SDONE
  } state_t;

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v == LTR_Z) ? LTR_A : v + 5'd1;
  endfunction

endpackage

// File: rtl/enigma_step_controller_if.sv
// Bundle of keypad, seek, rotor and scrambler-chain signals around the step controller.
interface enigma_step_controller_if;
  import enigma_step_controller_pkg::*;

  logic                   key_valid;
  logic [4:0]             key_code;
  logic                   key_ready;
  logic                   set_valid;
  logic [4:0]             set_pos_r;
  logic [4:0]             set_pos_m;
  logic [4:0]             set_pos_l;
  logic                   set_done;
  logic                   notch_r;
  logic                   notch_m;
  logic                   rotate_r;
  logic                   rotate_m;
  logic                   rotate_l;
  logic [NUM_LETTERS-1:0] enc_drive;
  logic [NUM_LETTERS-1:0] enc_return;
  logic                   out_valid;
  logic [4:0]             out_code;
  logic                   out_err;
  logic [4:0]             pos_r;
  logic [4:0]             pos_m;
  logic [4:0]             pos_l;

  modport master (
    output key_valid, key_code, set_valid, set_pos_r, set_pos_m, set_pos_l,
           notch_r, notch_m, enc_return,
    input  key_ready, set_done, rotate_r, rotate_m, rotate_l, enc_drive,
           out_valid, out_code, out_err, pos_r, pos_m, pos_l
  );

  modport slave (
    input  key_valid, key_code, set_valid, set_pos_r, set_pos_m, set_pos_l,
           notch_r, notch_m, enc_return,
    output key_ready, set_done, rotate_r, rotate_m, rotate_l, enc_drive,
           out_valid, out_code, out_err, pos_r, pos_m, pos_l
  );

endinterface

// File: rtl/enigma_step_controller_onehot26_to_code.sv
// One-hot letter to 5-bit code; err flags an all-zero or multi-hot input (code forced to 0).
module onehot26_to_code
  import enigma_step_controller_pkg::*;
(
  input  logic [NUM_LETTERS-1:0] onehot,
  output logic [4:0]             code,
  output logic                   err
);

  logic [4:0] ones;
  logic [4:0] idx;

  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (onehot[i]) begin
        ones = ones + 5'd1;
        idx  = 5'(i);
      end
    end
    err  = (ones != 5'd1);
    code = err ? LTR_A : idx;
  end

endmodule

// File: rtl/enigma_step_controller.sv
// Rotor stepping / encipher sequencer and position seeker for a three-rotor chain.
// state  | meaning
// IDLE   | waiting for a key or set request (key_ready high)
// STEP   | rotate pulses for the accepted key
// DRIVE  | letter held on enc_drive while the chain settles
// DONE   | out_valid strobe with the decoded result
// SEEK   | pulse every rotor still short of its target
// GAP    | mandatory low cycle between seek pulses
// SDONE  | set_done strobe
module enigma_step_controller
  import enigma_step_controller_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic                     clk,
  input logic                     reset,
  enigma_step_controller_if.slave bus
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [NUM_LETTERS-1:0] ONE_HOT_A = {{(NUM_LETTERS-1){1'b0}}, 1'b1};

  state_t state, state_n;

  logic [4:0]             key_lat, key_lat_n;
  logic [4:0]             tgt_r, tgt_m, tgt_l, tgt_r_n, tgt_m_n, tgt_l_n;
  logic [4:0]             pos_r, pos_m, pos_l, pos_r_n, pos_m_n, pos_l_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   rot_r, rot_m, rot_l, rot_r_n, rot_m_n, rot_l_n;
  logic [NUM_LETTERS-1:0] drive, drive_n;
  logic                   valid, valid_n, sdone, sdone_n, err, err_n, ready, ready_n;
  logic [4:0]             code, code_n;

  logic [4:0] dec_code;
  logic       dec_err;
  logic [4:0] seek_tr, seek_tm, seek_tl;
  logic       need_r, need_m, need_l, set_bad;

  onehot26_to_code u_dec (
    .onehot (bus.enc_return),
    .code   (dec_code),
    .err    (dec_err)
  );

  // In IDLE the targets come straight from the request so the first pulse lands in the cycle after accept.
  assign seek_tr = (state == S_IDLE) ? bus.set_pos_r : tgt_r;
  assign seek_tm = (state == S_IDLE) ? bus.set_pos_m : tgt_m;
  assign seek_tl = (state == S_IDLE) ? bus.set_pos_l : tgt_l;
  assign need_r  = (pos_r != seek_tr);
  assign need_m  = (pos_m != seek_tm);
  assign need_l  = (pos_l != seek_tl);
  assign set_bad = (bus.set_pos_r > LTR_Z) | (bus.set_pos_m > LTR_Z) | (bus.set_pos_l > LTR_Z);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      key_lat <= '0;
      tgt_r   <= '0;
      tgt_m   <= '0;
      tgt_l   <= '0;
      pos_r   <= '0;
      pos_m   <= '0;
      pos_l   <= '0;
      cnt     <= '0;
      rot_r   <= 1'b0;
      rot_m   <= 1'b0;
      rot_l   <= 1'b0;
      drive   <= '0;
      valid   <= 1'b0;
      sdone   <= 1'b0;
      err     <= 1'b0;
      code    <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_n;
      key_lat <= key_lat_n;
      tgt_r   <= tgt_r_n;
      tgt_m   <= tgt_m_n;
      tgt_l   <= tgt_l_n;
      pos_r   <= pos_r_n;
      pos_m   <= pos_m_n;
      pos_l   <= pos_l_n;
      cnt     <= cnt_n;
      rot_r   <= rot_r_n;
      rot_m   <= rot_m_n;
      rot_l   <= rot_l_n;
      drive   <= drive_n;
      valid   <= valid_n;
      sdone   <= sdone_n;
      err     <= err_n;
      code    <= code_n;
      ready   <= ready_n;
    end
  end

  always_comb begin
    state_n   = state;
    key_lat_n = key_lat;
    tgt_r_n   = tgt_r;
    tgt_m_n   = tgt_m;
    tgt_l_n   = tgt_l;
    pos_r_n   = pos_r;
    pos_m_n   = pos_m;
    pos_l_n   = pos_l;
    cnt_n     = cnt;
    rot_r_n   = 1'b0;
    rot_m_n   = 1'b0;
    rot_l_n   = 1'b0;
    drive_n   = '0;
    valid_n   = 1'b0;
    sdone_n   = 1'b0;
    err_n     = 1'b0;
    code_n    = '0;

    case (state)
      S_IDLE: begin
        if (ready && bus.set_valid) begin
          tgt_r_n = bus.set_pos_r;
          tgt_m_n = bus.set_pos_m;
          tgt_l_n = bus.set_pos_l;
          if (set_bad) begin
            state_n = S_SDONE;
            sdone_n = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n = S_SEEK;
            rot_r_n = need_r;
            rot_m_n = need_m;
            rot_l_n = need_l;
            if (need_r) pos_r_n = inc26(pos_r);
            if (need_m) pos_m_n = inc26(pos_m);
            if (need_l) pos_l_n = inc26(pos_l);
          end
        end else if (ready && bus.key_valid) begin
          key_lat_n = bus.key_code;
          if (bus.key_code > LTR_Z) begin
            state_n = S_DONE;
            valid_n = 1'b1;
            err_n   = 1'b1;
          end else begin
            // notch_m pulses the middle rotor too: the double step
            state_n = S_STEP;
            rot_r_n = 1'b1;
            rot_m_n = bus.notch_r | bus.notch_m;
            rot_l_n = bus.notch_m;
            pos_r_n = inc26(pos_r);
            if (bus.notch_r | bus.notch_m) pos_m_n = inc26(pos_m);
            if (bus.notch_m) pos_l_n = inc26(pos_l);
          end
        end
      end
      S_STEP: begin
        state_n = S_DRIVE;
        cnt_n   = CW'(SETTLE_CYCLES - 1);
        drive_n = ONE_HOT_A << key_lat;
      end
      S_DRIVE: begin
        if (cnt == '0) begin
          state_n = S_DONE;
          valid_n = 1'b1;
          code_n  = dec_code;
          err_n   = dec_err;
        end else begin
          cnt_n   = cnt - CW'(1);
          drive_n = ONE_HOT_A << key_lat;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_SEEK: begin
        if (rot_r || rot_m || rot_l) begin
          state_n = S_GAP;
        end else begin
          state_n = S_SDONE;
          sdone_n = 1'b1;
        end
      end
      S_GAP: begin
        state_n = S_SEEK;
        rot_r_n = need_r;
        rot_m_n = need_m;
        rot_l_n = need_l;
        if (need_r) pos_r_n = inc26(pos_r);
        if (need_m) pos_m_n = inc26(pos_m);
        if (need_l) pos_l_n = inc26(pos_l);
      end
      S_SDONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    ready_n = (state_n == S_IDLE);
  end

  assign bus.key_ready = ready;
  assign bus.set_done  = sdone;
  assign bus.rotate_r  = rot_r;
  assign bus.rotate_m  = rot_m;
  assign bus.rotate_l  = rot_l;
  assign bus.enc_drive = drive;
  assign bus.out_valid = valid;
  assign bus.out_code  = code;
  assign bus.out_err   = err;
  assign bus.pos_r     = pos_r;
  assign bus.pos_m     = pos_m;
  assign bus.pos_l     = pos_l;

endmodule

// File: tb/tb_enigma_step_controller.sv
// Directed bench for the step controller; the scrambler chain is modelled as a fixed +7 letter shift.
module tb_enigma_step_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic        ovr_en = 1'b0;
  logic [25:0] ovr_val = '0;

  enigma_step_controller_if bus();

  enigma_step_controller #(.SETTLE_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.enc_return = '0;
    if (ovr_en) bus.enc_return = ovr_val;
    else
      for (int i = 0; i < 26; i++)
        if (bus.enc_drive[i]) bus.enc_return[(i + 7) % 26] = 1'b1;
  end

  task automatic press(input logic [4:0] kc, input logic nr, input logic nm);
    bus.key_code  = kc;
    bus.notch_r   = nr;
    bus.notch_m   = nm;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.notch_r   = 1'b0;
    bus.notch_m   = 1'b0;
  endtask

  task automatic request_set(input logic [4:0] r, input logic [4:0] m, input logic [4:0] l);
    bus.set_pos_r = r;
    bus.set_pos_m = m;
    bus.set_pos_l = l;
    bus.set_valid = 1'b1;
    @(negedge clk);
    bus.set_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({bus.rotate_r, bus.rotate_m, bus.rotate_l} !== 3'b000) begin n_bad++; $display("FAIL rst_rotate got=%b exp=000", {bus.rotate_r, bus.rotate_m, bus.rotate_l}); end
    n_cmp++; if ({bus.pos_r, bus.pos_m, bus.pos_l} !== 15'd0) begin n_bad++; $display("FAIL rst_pos got=%0d/%0d/%0d exp=0/0/0", bus.pos_r, bus.pos_m, bus.pos_l); end
    n_cmp++; if ({bus.out_valid, bus.set_done, bus.out_err, bus.key_ready} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got=%b exp=0000", {bus.out_valid, bus.set_done, bus.out_err, bus.key_ready}); end
    n_cmp++; if (bus.enc_drive !== 26'h0) begin n_bad++; $display("FAIL rst_drive got=%h exp=0", bus.enc_drive); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.key_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", bus.key_ready); end
  endtask

  task automatic test_key_basic();
    press(5'd0, 1'b0, 1'b0);
    n_cmp++; if ({bus.rotate_r, bus.rotate_m, bus.rotate_l} !== 3'b100) begin n_bad++; $display("FAIL key_c1_rotate got=%b exp=100", {bus.rotate_r, bus.rotate_m, bus.rotate_l}); end
    n_cmp++; if (bus.pos_r !== 5'd1) begin n_bad++; $display("FAIL key_c1_pos_r got=%0d exp=1", bus.pos_r); end
    n_cmp++; if (bus.key_ready !== 1'b0) begin n_bad++; $display("FAIL key_c1_ready got=%b exp=0", bus.key_ready); end
    @(negedge clk);
    n_cmp++; if (bus.enc_drive !== 26'h1) begin n_bad++; $display("FAIL key_c2_drive got=%h exp=1", bus.enc_drive); end
    n_cmp++; if (bus.rotate_r !== 1'b0) begin n_bad++; $display("FAIL key_c2_rotate_r got=%b exp=0", bus.rotate_r); end
    @(negedge clk);
    n_cmp++; if (bus.enc_drive !== 26'h1) begin n_bad++; $display("FAIL key_c3_drive got=%h exp=1", bus.enc_drive); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL key_c3_valid got=%b exp=0", bus.out_valid); end
    @(negedge clk);
    n_cmp++; if ({bus.out_valid, bus.out_err} !== 2'b10) begin n_bad++; $display("FAIL key_c4_valid_err got=%b exp=10", {bus.out_valid, bus.out_err}); end
    n_cmp++; if (bus.out_code !== 5'd7) begin n_bad++; $display("FAIL key_c4_code got=%0d exp=7", bus.out_code); end
    n_cmp++; if (bus.enc_drive !== 26'h0) begin n_bad++; $display("FAIL key_c4_drive got=%h exp=0", bus.enc_drive); end
    @(negedge clk);
    n_cmp++; if ({bus.out_valid, bus.key_ready} !== 2'b01) begin n_bad++; $display("FAIL key_c5_valid_ready got=%b exp=01", {bus.out_valid, bus.key_ready}); end
  endtask

  task automatic test_notch_carry();
    press(5'd5, 1'b1, 1'b0);
    n_cmp++; if ({bus.rotate_r, bus.rotate_m, bus.rotate_l} !== 3'b110) begin n_bad++; $display("FAIL carry_rotate got=%b exp=110", {bus.rotate_r, bus.rotate_m, bus.rotate_l}); end
    n_cmp++; if ({bus.pos_r, bus.pos_m, bus.pos_l} !== {5'd2, 5'd1, 5'd0}) begin n_bad++; $display("FAIL carry_pos got=%0d/%0d/%0d exp=2/1/0", bus.pos_r, bus.pos_m, bus.pos_l); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus.out_valid, bus.out_code} !== {1'b1, 5'd12}) begin n_bad++; $display("FAIL carry_out got=%b/%0d exp=1/12", bus.out_valid, bus.out_code); end
    @(negedge clk);
  endtask

  task automatic test_double_step();
    press(5'd10, 1'b0, 1'b1);
    n_cmp++; if ({bus.rotate_r, bus.rotate_m, bus.rotate_l} !== 3'b111) begin n_bad++; $display("FAIL dstep_rotate got=%b exp=111", {bus.rotate_r, bus.rotate_m, bus.rotate_l}); end
    n_cmp++; if ({bus.pos_r, bus.pos_m, bus.pos_l} !== {5'd3, 5'd2, 5'd1}) begin n_bad++; $display("FAIL dstep_pos got=%0d/%0d/%0d exp=3/2/1", bus.pos_r, bus.pos_m, bus.pos_l); end
    @(negedge clk);
    n_cmp++; if ({bus.rotate_r, bus.rotate_m, bus.rotate_l} !== 3'b000) begin n_bad++; $display("FAIL dstep_c2_rotate got=%b exp=000", {bus.rotate_r, bus.rotate_m, bus.rotate_l}); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({bus.out_valid, bus.out_code} !== {1'b1, 5'd17}) begin n_bad++; $display("FAIL dstep_out got=%b/%0d exp=1/17", bus.out_valid, bus.out_code); end
    @(negedge clk);
  endtask

  task automatic test_seek();
    logic er, em, el, es;
    do_reset();
    request_set(5'd3, 5'd0, 5'd25);
    for (int c = 1; c <= 52; c++) begin
      er = (c == 1) || (c == 3) || (c == 5);
      em = 1'b0;
      el = (c % 2 == 1) && (c <= 49);
      es = (c == 52);
      n_cmp++; if ({bus.rotate_r, bus.rotate_m, bus.rotate_l, bus.set_done} !== {er, em, el, es}) begin
        n_bad++; $display("FAIL seek_c%0d got=%b exp=%b", c, {bus.rotate_r, bus.rotate_m, bus.rotate_l, bus.set_done}, {er, em, el, es});
      end
      if (c < 52) @(negedge clk);
    end
    n_cmp++; if ({bus.pos_r, bus.pos_m, bus.pos_l} !== {5'd3, 5'd0, 5'd25}) begin n_bad++; $display("FAIL seek_pos got=%0d/%0d/%0d exp=3/0/25", bus.pos_r, bus.pos_m, bus.pos_l); end
    n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL seek_err got=%b exp=0", bus.out_err); end
    @(negedge clk);
    n_cmp++; if (bus.key_ready !== 1'b1) begin n_bad++; $display("FAIL seek_ready got=%b exp=1", bus.key_ready); end
  endtask

  task automatic test_wrap_and_errors();
    int cyc;
    request_set(5'd25, 5'd0, 5'd25);
    cyc = 1;
    while (bus.set_done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (cyc != 46) begin n_bad++; $display("FAIL wrap_seek_cycles got=%0d exp=46", cyc); end
    n_cmp++; if (bus.pos_r !== 5'd25) begin n_bad++; $display("FAIL wrap_seek_pos_r got=%0d exp=25", bus.pos_r); end
    @(negedge clk);
    press(5'd2, 1'b0, 1'b0);
    n_cmp++; if (bus.pos_r !== 5'd0) begin n_bad++; $display("FAIL wrap_pos_r got=%0d exp=0", bus.pos_r); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus.out_valid, bus.out_code} !== {1'b1, 5'd9}) begin n_bad++; $display("FAIL wrap_out got=%b/%0d exp=1/9", bus.out_valid, bus.out_code); end
    @(negedge clk);
    press(5'd27, 1'b1, 1'b1);
    n_cmp++; if ({bus.out_valid, bus.out_err, bus.out_code} !== {1'b1, 1'b1, 5'd0}) begin n_bad++; $display("FAIL badkey_out got=%b/%b/%0d exp=1/1/0", bus.out_valid, bus.out_err, bus.out_code); end
    n_cmp++; if ({bus.rotate_r, bus.rotate_m, bus.rotate_l, bus.pos_r} !== {3'b000, 5'd0}) begin n_bad++; $display("FAIL badkey_rotate got=%b pos_r=%0d exp=000 pos_r=0", {bus.rotate_r, bus.rotate_m, bus.rotate_l}, bus.pos_r); end
    @(negedge clk);
    n_cmp++; if ({bus.key_ready, bus.out_valid} !== 2'b10) begin n_bad++; $display("FAIL badkey_c2 got=%b exp=10", {bus.key_ready, bus.out_valid}); end
    ovr_en  = 1'b1;
    ovr_val = 26'h5;
    press(5'd1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus.out_valid, bus.out_err, bus.out_code} !== {1'b1, 1'b1, 5'd0}) begin n_bad++; $display("FAIL multihot_out got=%b/%b/%0d exp=1/1/0", bus.out_valid, bus.out_err, bus.out_code); end
    @(negedge clk);
    ovr_en = 1'b0;
    request_set(5'd26, 5'd0, 5'd0);
    n_cmp++; if ({bus.set_done, bus.out_err, bus.rotate_r, bus.rotate_m, bus.rotate_l} !== 5'b11000) begin n_bad++; $display("FAIL badset got=%b exp=11000", {bus.set_done, bus.out_err, bus.rotate_r, bus.rotate_m, bus.rotate_l}); end
    n_cmp++; if (bus.pos_r !== 5'd1) begin n_bad++; $display("FAIL badset_pos_r got=%0d exp=1", bus.pos_r); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_seek();
    request_set(5'd20, 5'd20, 5'd20);
    repeat (8) @(negedge clk);
    n_cmp++; if ({bus.rotate_r, bus.rotate_m, bus.rotate_l} !== 3'b111) begin n_bad++; $display("FAIL midrst_pre got=%b exp=111", {bus.rotate_r, bus.rotate_m, bus.rotate_l}); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if ({bus.rotate_r, bus.rotate_m, bus.rotate_l} !== 3'b000) begin n_bad++; $display("FAIL midrst_rotate got=%b exp=000", {bus.rotate_r, bus.rotate_m, bus.rotate_l}); end
    n_cmp++; if ({bus.pos_r, bus.pos_m, bus.pos_l} !== 15'd0) begin n_bad++; $display("FAIL midrst_pos got=%0d/%0d/%0d exp=0/0/0", bus.pos_r, bus.pos_m, bus.pos_l); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.key_ready, bus.pos_r, bus.pos_m, bus.pos_l} !== {1'b1, 15'd0}) begin n_bad++; $display("FAIL midrst_after got=%b pos=%0d/%0d/%0d exp=1 pos=0/0/0", bus.key_ready, bus.pos_r, bus.pos_m, bus.pos_l); end
    bus.key_code  = 5'd4;
    bus.key_valid = 1'b1;
    request_set(5'd1, 5'd0, 5'd0);
    n_cmp++; if ({bus.rotate_r, bus.rotate_m, bus.rotate_l, bus.pos_r} !== {3'b100, 5'd1}) begin n_bad++; $display("FAIL both_c1 got=%b pos_r=%0d exp=100 pos_r=1", {bus.rotate_r, bus.rotate_m, bus.rotate_l}, bus.pos_r); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus.set_done, bus.out_valid} !== 2'b10) begin n_bad++; $display("FAIL both_c4 got=%b exp=10", {bus.set_done, bus.out_valid}); end
    @(negedge clk);
    n_cmp++; if (bus.key_ready !== 1'b1) begin n_bad++; $display("FAIL both_c5_ready got=%b exp=1", bus.key_ready); end
    @(negedge clk);
    bus.key_valid = 1'b0;
    n_cmp++; if ({bus.rotate_r, bus.pos_r} !== {1'b1, 5'd2}) begin n_bad++; $display("FAIL both_pending_step got=%b pos_r=%0d exp=1 pos_r=2", bus.rotate_r, bus.pos_r); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus.out_valid, bus.out_err, bus.out_code} !== {1'b1, 1'b0, 5'd11}) begin n_bad++; $display("FAIL both_pending_out got=%b/%b/%0d exp=1/0/11", bus.out_valid, bus.out_err, bus.out_code); end
    @(negedge clk);
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.set_valid = 1'b0;
    bus.set_pos_r = '0;
    bus.set_pos_m = '0;
    bus.set_pos_l = '0;
    bus.notch_r   = 1'b0;
    bus.notch_m   = 1'b0;
    test_reset();
    test_key_basic();
    test_notch_carry();
    test_double_step();
    test_seek();
    test_wrap_and_errors();
    test_reset_mid_seek();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
